// File: rtl/vmult_pkg.sv
// Shared types and constants for the vector multiply sequencer.
package vmult_pkg;

  localparam int unsigned FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } vseq_state_t;

endpackage

// File: rtl/vmult_seq_if.sv
// Command/result bundle between the vector register file side and vmult_seq.
interface vmult_seq_if
  import vmult_pkg::*;
#(
  parameter int unsigned LANES = 8,
  parameter int unsigned LW    = $clog2(LANES + 1)
);

  logic                      Start;
  logic [LW-1:0]             Length;
  logic [FP16_W*LANES-1:0]   VecA;
  logic [FP16_W*LANES-1:0]   VecB;
  logic [FP16_W*LANES-1:0]   Result;
  logic [LANES-1:0]          OvfMask;
  logic                      OvfAny;
  logic                      Busy;
  logic                      Done;

  modport master (
    output Start, Length, VecA, VecB,
    input  Result, OvfMask, OvfAny, Busy, Done
  );

  modport slave (
    input  Start, Length, VecA, VecB,
    output Result, OvfMask, OvfAny, Busy, Done
  );

endinterface

// File: rtl/vmult_seq_vmultp.sv
// Half-precision multiplier with one output pipeline register and no reset.
// Handles subnormal inputs/outputs, round-to-nearest-even, inf/NaN operands;
// Overflow flags finite operands whose product rounds to infinity.
module VMULTp
  import vmult_pkg::*;
(
  input  logic              Clk,
  input  logic [FP16_W-1:0] A,
  input  logic [FP16_W-1:0] B,
  output logic [FP16_W-1:0] product,
  output logic              Overflow
);

  logic              sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [10:0]       sa, sb;
  logic [21:0]       p, pn;
  logic [55:0]       wide;
  logic [4:0]        e_fld;
  logic [9:0]        frac;
  logic              guard, sticky, rnd;
  logic [15:0]       sum;
  logic [FP16_W-1:0] res_d;
  logic              ovf_d;
  int                ea, eb, pos, e, sh;

  // Unpack, multiply significands, normalise, denormalise if needed, round.
  always_comb begin
    sgn    = A[15] ^ B[15];
    a_nan  = (&A[14:10]) & (|A[9:0]);
    b_nan  = (&B[14:10]) & (|B[9:0]);
    a_inf  = (&A[14:10]) & ~(|A[9:0]);
    b_inf  = (&B[14:10]) & ~(|B[9:0]);
    a_zero = ~(|A[14:0]);
    b_zero = ~(|B[14:0]);
    sa     = {|A[14:10], A[9:0]};
    sb     = {|B[14:10], B[9:0]};
    ea     = (|A[14:10]) ? int'(A[14:10]) : 1;
    eb     = (|B[14:10]) ? int'(B[14:10]) : 1;
    p      = 22'(sa) * 22'(sb);
    pos    = 0;
    for (int unsigned i = 0; i < 22; i++) begin
      if (p[i]) pos = int'(i);
    end
    pn = p << (21 - pos);
    e  = pos + ea + eb - 35;
    sh = (e < 1) ? (((1 - e) > 25) ? 25 : (1 - e)) : 0;
    wide   = {pn, 34'b0} >> sh;
    // Bit 55 survives only when no denormalising shift happened, i.e. a normal result.
    e_fld  = wide[55] ? 5'(e) : 5'd0;
    frac   = wide[54:45];
    guard  = wide[44];
    sticky = |wide[43:0];
    rnd    = guard & (sticky | frac[0]);
    // Rounding carry may ripple from the fraction into the exponent field.
    sum    = {1'b0, e_fld, frac} + 16'(rnd);

    ovf_d = 1'b0;
    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
      res_d = 16'h7E00;
    end else if (a_inf | b_inf) begin
      res_d = {sgn, 15'h7C00};
    end else if (a_zero | b_zero) begin
      res_d = {sgn, 15'h0000};
    end else if ((e > 30) || (sum >= 16'h7C00)) begin
      res_d = {sgn, 15'h7C00};
      ovf_d = 1'b1;
    end else begin
      res_d = {sgn, sum[14:0]};
    end
  end

  // Single pipeline stage; consumers qualify it with their own valid tracking.
  always_ff @(posedge Clk) begin
    product  <= res_d;
    Overflow <= ovf_d;
  end

endmodule

// File: rtl/vmult_seq.sv
// Streams a latched pair of fp16 vectors through one VMULTp and gathers the
// products and per-element overflow flags, pulsing Done when complete.
module vmult_seq
  import vmult_pkg::*;
#(
  parameter int unsigned LANES = 8,
  parameter int unsigned LW    = $clog2(LANES + 1)
) (
  input  logic      Clk2,
  input  logic      Reset,
  vmult_seq_if.slave bus
);

  vseq_state_t             state_q, state_d;
  logic [LW-1:0]           idx_q, idx_d;
  logic [LW-1:0]           len_q, len_clamp;
  logic [FP16_W*LANES-1:0] opa_q, opb_q, res_q;
  logic [LANES-1:0]        ovf_q;
  logic                    ovf_any_q;
  logic                    vld_q;
  logic [LW-1:0]           cidx_q;
  logic [FP16_W-1:0]       mul_a, mul_b, mul_p;
  logic                    mul_ovf;
  logic                    accept;

  assign len_clamp = (bus.Length > LW'(LANES)) ? LW'(LANES) : bus.Length;
  assign accept    = (state_q == IDLE) && bus.Start;

  // Next-state and issue index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          idx_d   = '0;
          state_d = (len_clamp == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == (len_q - 1'b1)) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and issue-index registers.
  always_ff @(posedge Clk2) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Multiplier operands: current element while issuing, zero otherwise.
  always_comb begin
    mul_a = FP16_ZERO;
    mul_b = FP16_ZERO;
    if (state_q == ISSUE) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (LW'(i) == idx_q) begin
          mul_a = opa_q[i*FP16_W +: FP16_W];
          mul_b = opb_q[i*FP16_W +: FP16_W];
        end
      end
    end
  end

  VMULTp u_mul (
    .Clk      (Clk2),
    .A        (mul_a),
    .B        (mul_b),
    .product  (mul_p),
    .Overflow (mul_ovf)
  );

  // Operand latch on accept, valid shadow of the multiplier stage, result capture.
  always_ff @(posedge Clk2) begin
    if (Reset) begin
      opa_q     <= '0;
      opb_q     <= '0;
      len_q     <= '0;
      res_q     <= '0;
      ovf_q     <= '0;
      ovf_any_q <= 1'b0;
      vld_q     <= 1'b0;
      cidx_q    <= '0;
    end else begin
      vld_q  <= (state_q == ISSUE);
      cidx_q <= idx_q;
      if (accept) begin
        opa_q     <= bus.VecA;
        opb_q     <= bus.VecB;
        len_q     <= len_clamp;
        res_q     <= '0;
        ovf_q     <= '0;
        ovf_any_q <= 1'b0;
      end else if (vld_q) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (LW'(i) == cidx_q) begin
            res_q[i*FP16_W +: FP16_W] <= mul_p;
            ovf_q[i]                  <= mul_ovf;
          end
        end
        ovf_any_q <= ovf_any_q | mul_ovf;
      end
    end
  end

  assign bus.Result  = res_q;
  assign bus.OvfMask = ovf_q;
  assign bus.OvfAny  = ovf_any_q;
  assign bus.Busy    = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.Done    = (state_q == DONE);

endmodule

// File: tb/tb_vmult_seq.sv
// Directed bench for vmult_seq with hand-computed fp16 products.
module tb_vmult_seq;

  localparam int unsigned LANES = 8;
  localparam int unsigned LW    = $clog2(LANES + 1);

  logic Clk2 = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;

  vmult_seq_if #(.LANES(LANES), .LW(LW)) bus ();

  vmult_seq #(.LANES(LANES), .LW(LW)) dut (
    .Clk2  (Clk2),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk2 = ~Clk2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input logic [15:0] e0, e1, e2, e3, e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  task automatic tick();
    @(posedge Clk2);
    #1;
  endtask

  task automatic start_cmd(input logic [LW-1:0] len, input logic [127:0] a, input logic [127:0] b);
    bus.Start  = 1'b1;
    bus.Length = len;
    bus.VecA   = a;
    bus.VecB   = b;
    tick();
    bus.Start  = 1'b0;
  endtask

  // Called in cycle t+cyc0; returns the cycle offset where Done is seen.
  task automatic wait_done(input int cyc0, output int cyc, output int nbusy);
    cyc   = cyc0;
    nbusy = 0;
    while (!bus.Done && cyc < 40) begin
      if (bus.Busy) nbusy++;
      tick();
      cyc++;
    end
  endtask

  logic [127:0] fa, fb, fres, hres, oa, ob;
  int cyc, nb;
  logic saw_done;

  initial begin
    fa   = lanes(16'hBC00, 16'h4000, 16'h4080, 16'h3C00, 16'hBC00, 16'h4000, 16'h4080, 16'h3C00);
    fb   = lanes(16'h3C00, 16'h4200, 16'h0201, 16'h3C00, 16'h3C00, 16'h4200, 16'h0201, 16'h3C00);
    fres = lanes(16'hBC00, 16'h4600, 16'h0482, 16'h3C00, 16'hBC00, 16'h4600, 16'h0482, 16'h3C00);
    hres = lanes(16'hBC00, 16'h4600, 16'h0482, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0);
    oa   = lanes(16'h3C00, 16'h7AAA, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);
    ob   = lanes(16'h4000, 16'h7ADE, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00);

    bus.Start  = 1'b0;
    bus.Length = '0;
    bus.VecA   = '0;
    bus.VecB   = '0;
    Reset      = 1'b1;
    tick();
    tick();
    check_eq("rst_result", bus.Result, '0);
    check_eq("rst_ovfmask", bus.OvfMask, '0);
    check_eq("rst_ovfany", bus.OvfAny, 1'b0);
    check_eq("rst_busy", bus.Busy, 1'b0);
    check_eq("rst_done", bus.Done, 1'b0);
    Reset = 1'b0;
    tick();

    // Basic 1.0 * 1.0
    start_cmd(LW'(1), lanes(16'h3C00, 0, 0, 0, 0, 0, 0, 0), lanes(16'h3C00, 0, 0, 0, 0, 0, 0, 0));
    wait_done(1, cyc, nb);
    check_eq("basic_latency", cyc, 3);
    check_eq("basic_busy", nb, 2);
    check_eq("basic_result", bus.Result, lanes(16'h3C00, 0, 0, 0, 0, 0, 0, 0));
    check_eq("basic_ovfany", bus.OvfAny, 1'b0);
    tick();
    check_eq("basic_done_pulse", bus.Done, 1'b0);
    check_eq("basic_hold", bus.Result, lanes(16'h3C00, 0, 0, 0, 0, 0, 0, 0));

    // Full 8 lanes, including a subnormal operand
    start_cmd(LW'(8), fa, fb);
    wait_done(1, cyc, nb);
    check_eq("full_latency", cyc, 10);
    check_eq("full_busy", nb, 9);
    check_eq("full_result", bus.Result, fres);
    check_eq("full_ovfmask", bus.OvfMask, '0);
    tick();

    // Overflow in element 1; lanes beyond length stay zero
    start_cmd(LW'(2), oa, ob);
    wait_done(1, cyc, nb);
    check_eq("ovf_latency", cyc, 4);
    check_eq("ovf_result", bus.Result, lanes(16'h4000, 16'h7C00, 0, 0, 0, 0, 0, 0));
    check_eq("ovf_mask", bus.OvfMask, 8'b0000_0010);
    check_eq("ovf_any", bus.OvfAny, 1'b1);
    tick();

    // Length 0 completes at once and clears previous results
    start_cmd(LW'(0), fa, fb);
    wait_done(1, cyc, nb);
    check_eq("len0_latency", cyc, 1);
    check_eq("len0_busy", nb, 0);
    check_eq("len0_result", bus.Result, '0);
    check_eq("len0_ovfany", bus.OvfAny, 1'b0);
    tick();

    // Length 15 clamps to 8
    start_cmd(LW'(15), fa, fb);
    wait_done(1, cyc, nb);
    check_eq("len15_latency", cyc, 10);
    check_eq("len15_busy", nb, 9);
    check_eq("len15_result", bus.Result, fres);
    tick();

    // Second Start during ISSUE is ignored
    start_cmd(LW'(4), fa, fb);
    tick();
    start_cmd(LW'(8), oa, ob);
    wait_done(3, cyc, nb);
    check_eq("busy_start_latency", cyc, 6);
    check_eq("busy_start_result", bus.Result, hres);
    check_eq("busy_start_ovfany", bus.OvfAny, 1'b0);

    // Back-to-back: Start in first IDLE cycle after Done
    tick();
    check_eq("b2b_idle_busy", bus.Busy, 1'b0);
    start_cmd(LW'(1), lanes(16'h4000, 0, 0, 0, 0, 0, 0, 0), lanes(16'h4200, 0, 0, 0, 0, 0, 0, 0));
    wait_done(1, cyc, nb);
    check_eq("b2b_latency", cyc, 3);
    check_eq("b2b_result", bus.Result, lanes(16'h4600, 0, 0, 0, 0, 0, 0, 0));
    tick();

    // Reset in cycle t+2 of a Length=4 command
    start_cmd(LW'(4), fa, fb);
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_eq("midrst_result", bus.Result, '0);
    check_eq("midrst_ovfmask", bus.OvfMask, '0);
    check_eq("midrst_ovfany", bus.OvfAny, 1'b0);
    check_eq("midrst_busy", bus.Busy, 1'b0);
    check_eq("midrst_done", bus.Done, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.Done) saw_done = 1'b1;
    end
    check_eq("midrst_no_done", saw_done, 1'b0);
    check_eq("midrst_discard", bus.Result, '0);

    // Reset simultaneous with Start wins
    bus.Start  = 1'b1;
    bus.Length = LW'(1);
    bus.VecA   = fa;
    bus.VecB   = fb;
    Reset      = 1'b1;
    tick();
    bus.Start  = 1'b0;
    Reset      = 1'b0;
    tick();
    check_eq("rst_start_busy", bus.Busy, 1'b0);
    check_eq("rst_start_result", bus.Result, '0);

    // Recovery command after reset
    start_cmd(LW'(1), lanes(16'hBC00, 0, 0, 0, 0, 0, 0, 0), lanes(16'h4200, 0, 0, 0, 0, 0, 0, 0));
    wait_done(1, cyc, nb);
    check_eq("recover_latency", cyc, 3);
    check_eq("recover_result", bus.Result, lanes(16'hC200, 0, 0, 0, 0, 0, 0, 0));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
